// File: rtl/step_ctrl.sv
// step_ctrl: clock-enable controller for a teaching CPU.
// Issues single-cycle cpu_en pulses from either a slow tick (RUN mode) or a
// debounced pushbutton (STEP mode); a halt request freezes it until reset.
// Optional feature: define STEP_COUNT_EN to build the saturating step_count
// counter; otherwise step_count is tied to zero.
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt,
    output logic        cpu_en,
    output logic        running,
    output logic [31:0] step_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STEP,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t        state;
    logic [1:0]    tick_sync;
    logic [1:0]    run_sync;
    logic [1:0]    btn_sync;
    logic          tick_prev;
    logic          btn_acc;
    logic          btn_acc_prev;
    logic [CW-1:0] db_cnt;
    logic          tick_evt;
    logic          step_evt;

    // Two-flop synchronizers for the asynchronous board inputs.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, which is what makes a shift chain work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_sync <= 2'b00;
            run_sync  <= 2'b00;
            btn_sync  <= 2'b00;
            tick_prev <= 1'b0;
        end else begin
            tick_sync <= {tick_sync[0], tick_in};
            run_sync  <= {run_sync[0], run_sw};
            btn_sync  <= {btn_sync[0], step_btn};
            tick_prev <= tick_sync[1];
        end
    end

    // Debounce: accept a new button level only after it has differed from the
    // accepted level for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt       <= '0;
            btn_acc      <= 1'b0;
            btn_acc_prev <= 1'b0;
        end else begin
            btn_acc_prev <= btn_acc;
            if (btn_sync[1] == btn_acc) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_MAX) begin
                btn_acc <= btn_sync[1];
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

    // Single-cycle events; both are pure functions of registers, so no
    // combinational feedback or latch can arise here.
    assign tick_evt = tick_sync[1] & ~tick_prev;
    assign step_evt = btn_acc & ~btn_acc_prev;

    // Mode FSM with registered cpu_en/running. Events are judged against the
    // current state; halt overrides everything. The ~cpu_en term keeps pulses
    // apart when a mode switch lines up two events in adjacent cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_STEP;
            cpu_en  <= 1'b0;
            running <= 1'b0;
        end else if (halt) begin
            state   <= ST_HALT;
            cpu_en  <= 1'b0;
            running <= 1'b0;
        end else begin
            case (state)
                ST_STEP: begin
                    cpu_en <= step_evt & ~cpu_en;
                    if (run_sync[1]) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cpu_en <= tick_evt & ~cpu_en;
                    if (!run_sync[1]) begin
                        state   <= ST_STEP;
                        running <= 1'b0;
                    end
                end
                default: begin
                    cpu_en  <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_COUNT_EN
    logic [31:0] count_q;

    // Saturating count of issued cpu_en pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else if (cpu_en && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign step_count = count_q;
`else
    assign step_count = 32'd0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed scenarios plus randomized stimulus for step_ctrl,
// compared every cycle against a behavioural model of the controller.
module tb_step_ctrl;

    localparam int DEB = 4;
`ifdef STEP_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt = 1'b0;
    logic        cpu_en;
    logic        running;
    logic [31:0] step_count;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int p0;
    bit force_max = 1'b0;

    step_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt       (halt),
        .cpu_en     (cpu_en),
        .running    (running),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_STEP, M_RUN, M_HALT} mode_t;
    mode_t       m_mode = M_STEP;
    bit          m_cpu_en = 1'b0;
    bit          m_running = 1'b0;
    logic [31:0] m_count = 32'd0;
    // raw samples taken one and two edges ago, and whether those edges were in reset
    bit tick_d1, tick_d2, run_d1, run_d2, btn_d1, btn_d2, rst_d1, rst_d2;
    bit m_tick_prev, m_acc, m_acc_rose;
    int edge_no = 0;
    int m_last_agree = 0;

    always @(posedge clk) begin : model
        bit blank, ts, rs, bs, tick_evt, step_evt, pulse;
        edge_no++;
        // A synchronized value is the input two edges ago, or 0 if reset
        // occurred in between.
        blank = rst_d1 || rst_d2;
        ts = blank ? 1'b0 : tick_d2;
        rs = blank ? 1'b0 : run_d2;
        bs = blank ? 1'b0 : btn_d2;
        tick_d2 = tick_d1; tick_d1 = tick_in;
        run_d2  = run_d1;  run_d1  = run_sw;
        btn_d2  = btn_d1;  btn_d1  = step_btn;
        rst_d2  = rst_d1;  rst_d1  = !rst_n;
        if (!rst_n) begin
            m_mode = M_STEP; m_cpu_en = 1'b0; m_running = 1'b0; m_count = 32'd0;
            m_tick_prev = 1'b0; m_acc = 1'b0; m_acc_rose = 1'b0; m_last_agree = edge_no;
        end else begin
            tick_evt = ts && !m_tick_prev;
            m_tick_prev = ts;
            step_evt = m_acc_rose;
            m_acc_rose = 1'b0;
            // accept a level after DEB consecutive disagreeing samples
            if (bs == m_acc) m_last_agree = edge_no;
            else if (edge_no - m_last_agree >= DEB) begin
                m_acc = bs; m_acc_rose = bs; m_last_agree = edge_no;
            end
            pulse = 1'b0;
            if (halt) m_mode = M_HALT;
            else if (m_mode == M_STEP) begin
                pulse = step_evt;
                if (rs) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                pulse = tick_evt;
                if (!rs) m_mode = M_STEP;
            end
            if (m_cpu_en) pulse = 1'b0;
            if (CNT_EN && m_cpu_en && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            m_cpu_en = pulse;
            m_running = (m_mode == M_RUN);
        end
        if (force_max) m_count = 32'hFFFF_FFFF;
    end

    // Per-cycle comparison against the model, sampled after the edge settles.
    always @(posedge clk) begin
        #1;
        if (cpu_en === 1'b1) pulses++;
        check("cpu_en", {31'd0, cpu_en}, {31'd0, m_cpu_en});
        check("running", {31'd0, running}, {31'd0, m_running});
        check("step_count", step_count, m_count);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_pulses(input int n);
        repeat (n) begin
            tick_in = 1'b1; cycles(10);
            tick_in = 1'b0; cycles(10);
        end
    endtask

    initial begin
        // reset state
        rst_n = 1'b0; cycles(3);
        check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("reset_running", {31'd0, running}, 32'd0);
        check("reset_step_count", step_count, 32'd0);
        rst_n = 1'b1;

        // RUN mode: 5 ticks -> 5 pulses, 2 edges after sampling
        run_sw = 1'b1; cycles(5);
        check("run_entered", {31'd0, running}, 32'd1);
        p0 = pulses;
        tick_in = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 check("lat_n1", {31'd0, cpu_en}, 32'd0);
        @(posedge clk); #1 check("lat_n2", {31'd0, cpu_en}, 32'd1);
        @(posedge clk); #1 check("lat_n3", {31'd0, cpu_en}, 32'd0);
        cycles(7);
        tick_in = 1'b0; cycles(10);
        tick_pulses(4); cycles(5);
        check("run_5_pulses", pulses - p0, 32'd5);
        check("run_5_count", step_count, CNT_EN ? 32'd5 : 32'd0);

        // STEP mode ignores ticks; returning to RUN resumes on next tick
        run_sw = 1'b0; cycles(5);
        check("step_entered", {31'd0, running}, 32'd0);
        p0 = pulses;
        tick_pulses(3);
        check("step_ignores_tick", pulses - p0, 32'd0);
        run_sw = 1'b1; cycles(5);
        tick_pulses(1);
        check("run_resumes", pulses - p0, 32'd1);

        // STEP mode debounce
        run_sw = 1'b0; cycles(5);
        p0 = pulses;
        repeat (6) begin step_btn = ~step_btn; cycles(2); end
        check("bounce_no_pulse", pulses - p0, 32'd0);
        step_btn = 1'b1; cycles(20);
        check("held_one_pulse", pulses - p0, 32'd1);
        step_btn = 1'b0; cycles(2);
        step_btn = 1'b1; cycles(10);
        check("short_low_no_pulse", pulses - p0, 32'd1);
        step_btn = 1'b0; cycles(10);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 5) == 0) tick_in = ~tick_in;
            if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
            rst_n = ($urandom_range(0, 299) != 0);
            cycles(1);
        end
        rst_n = 1'b1; tick_in = 1'b0; step_btn = 1'b0; run_sw = 1'b1;
        cycles(10);

        // reset between tick edge and pulse discards the pulse
        p0 = pulses;
        tick_in = 1'b1;
        @(posedge clk);
        cycles(2);
        rst_n = 1'b0; tick_in = 1'b0; cycles(3);
        check("rst_mid_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_mid_running", {31'd0, running}, 32'd0);
        check("rst_mid_count", step_count, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1 check("rst_release_no_pulse", {31'd0, cpu_en}, 32'd0);
        cycles(5);
        check("rst_discard_pulse", pulses - p0, 32'd0);

        // saturation of step_count
`ifdef STEP_COUNT_EN
        force_max = 1'b1;
        force dut.count_q = 32'hFFFF_FFFF;
        cycles(1);
        release dut.count_q;
        force_max = 1'b0;
`endif
        p0 = pulses;
        tick_pulses(1); cycles(3);
        check("sat_pulse", pulses - p0, 32'd1);
        check("sat_count", step_count, CNT_EN ? 32'hFFFF_FFFF : 32'd0);

        // halt in the cycle the tick event is detected
        p0 = pulses;
        tick_in = 1'b1;
        @(posedge clk);
        cycles(2);
        halt = 1'b1; cycles(1);
        halt = 1'b0; cycles(5);
        check("halt_no_pulse", pulses - p0, 32'd0);
        check("halt_running", {31'd0, running}, 32'd0);
        tick_in = 1'b0; cycles(5);
        tick_pulses(2);
        run_sw = 1'b0; cycles(5);
        step_btn = 1'b1; cycles(15);
        step_btn = 1'b0; cycles(15);
        run_sw = 1'b1; cycles(5);
        tick_pulses(1);
        check("halt_sticky_pulses", pulses - p0, 32'd0);
        check("halt_sticky_running", {31'd0, running}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
